// File: rtl/trig_demux_1_4.sv
// Trigger distributor: synchronises trig_in, detects its rising edge and routes a
// fixed-width pulse to one of four channels, with re-trigger holdoff and per-channel counters.
module trig_demux_1_4 #(
  parameter int PULSE_W = 4,
  parameter int HOLDOFF = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_in,
  input  logic               s0,
  input  logic               s1,
  input  logic               cnt_clr,
  input  logic [1:0]         cnt_sel,
  output logic               out_a,
  output logic               out_b,
  output logic               out_c,
  output logic               out_d,
  output logic               busy,
  output logic               missed,
  output logic [COUNT_W-1:0] cnt_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [7:0]         PULSE_LD    = 8'(PULSE_W - 1);
  localparam logic [7:0]         HOLD_LD     = 8'(HOLDOFF - 1);
  localparam bit                 HAS_HOLDOFF = (HOLDOFF > 0);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         tmr_q, tmr_d;
  logic [1:0]         sel_q, sel_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic               missed_q, missed_d;
  logic [COUNT_W-1:0] cnt_q [4];
  logic [COUNT_W-1:0] cnt_d [4];
  logic               rise;
  logic               accept;
  logic               pulse_on;

  assign rise   = sync2_q & ~sync3_q;
  assign accept = (state_q == ST_IDLE) && rise;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          sel_d   = {s1, s0};
          state_d = ST_PULSE;
          tmr_d   = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_q == 8'd0) begin
          if (HAS_HOLDOFF) begin
            state_d = ST_HOLDOFF;
            tmr_d   = HOLD_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear in the same cycle as an increment or a dropped edge takes priority.
  always_comb begin
    missed_d = cnt_clr ? 1'b0 : (missed_q | (rise & (state_q != ST_IDLE)));
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (accept && ({s1, s0} == 2'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= 8'd0;
      sel_q    <= 2'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      missed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sel_q    <= sel_d;
      sync1_q  <= trig_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      missed_q <= missed_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pulse_on = (state_q == ST_PULSE);
  assign out_a    = pulse_on && (sel_q == 2'd0);
  assign out_b    = pulse_on && (sel_q == 2'd1);
  assign out_c    = pulse_on && (sel_q == 2'd2);
  assign out_d    = pulse_on && (sel_q == 2'd3);
  assign busy     = (state_q != ST_IDLE);
  assign missed   = missed_q;
  assign cnt_out  = cnt_q[cnt_sel];

endmodule

// File: tb/tb_trig_demux_1_4.sv
// Directed bench for trig_demux_1_4: three instances cover the default, the
// single-cycle/no-holdoff, and the narrow-counter configurations.
module tb_trig_demux_1_4;

  logic       clk, rst_n, s0, s1, cnt_clr;
  logic [1:0] cnt_sel;
  logic       trig0, trig1, trig2;
  wire  [3:0] o0, o1, o2;
  wire        busy0, busy1, busy2;
  wire        missed0, missed1, missed2;
  wire [15:0] cnt0, cnt1;
  wire  [3:0] cnt2;
  int         n_tests = 0;
  int         n_fail  = 0;

  trig_demux_1_4 dut0 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig0), .s0(s0), .s1(s1),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .out_a(o0[0]), .out_b(o0[1]), .out_c(o0[2]), .out_d(o0[3]),
    .busy(busy0), .missed(missed0), .cnt_out(cnt0)
  );

  trig_demux_1_4 #(.PULSE_W(1), .HOLDOFF(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig1), .s0(s0), .s1(s1),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .out_a(o1[0]), .out_b(o1[1]), .out_c(o1[2]), .out_d(o1[3]),
    .busy(busy1), .missed(missed1), .cnt_out(cnt1)
  );

  trig_demux_1_4 #(.COUNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig2), .s0(s0), .s1(s1),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .out_a(o2[0]), .out_b(o2[1]), .out_c(o2[2]), .out_d(o2[3]),
    .busy(busy2), .missed(missed2), .cnt_out(cnt2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    trig0   = 1'b0;
    trig1   = 1'b0;
    trig2   = 1'b0;
    s0      = 1'b0;
    s1      = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o0, o1, o2} !== 12'h000) begin
      n_fail++; $display("FAIL reset_outs got %h exp 000", {o0, o1, o2});
    end
    n_tests++;
    if ({busy0, busy1, busy2, missed0, missed1, missed2} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000000",
                         {busy0, busy1, busy2, missed0, missed1, missed2});
    end
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      n_tests++;
      if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 4'd0) begin
        n_fail++; $display("FAIL reset_cnt sel=%0d got %0d/%0d/%0d exp 0", c, cnt0, cnt1, cnt2);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_o;
    logic       exp_busy;
    do_reset();
    {s1, s0} = 2'b10;
    trig0    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_o    = (k >= 3 && k <= 6) ? 4'b0100 : 4'b0000;
      exp_busy = (k >= 3 && k <= 14);
      n_tests++;
      if (o0 !== exp_o) begin
        n_fail++; $display("FAIL basic_out k=%0d got %b exp %b", k, o0, exp_o);
      end
      n_tests++;
      if (busy0 !== exp_busy) begin
        n_fail++; $display("FAIL basic_busy k=%0d got %b exp %b", k, busy0, exp_busy);
      end
      if (k == 5) trig0 = 1'b0;
    end
    cnt_sel = 2'd2;
    #1;
    n_tests++;
    if (cnt0 !== 16'd1) begin
      n_fail++; $display("FAIL basic_cnt got %0d exp 1", cnt0);
    end
    n_tests++;
    if (missed0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_missed got %b exp 0", missed0);
    end
  endtask

  task automatic test_holdoff();
    logic [3:0] exp_o;
    logic       exp_m;
    do_reset();
    {s1, s0} = 2'b10;
    trig0    = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_o = ((k >= 3 && k <= 6) || (k >= 16 && k <= 19)) ? 4'b0100 : 4'b0000;
      exp_m = (k >= 9);
      n_tests++;
      if (o0 !== exp_o) begin
        n_fail++; $display("FAIL holdoff_out k=%0d got %b exp %b", k, o0, exp_o);
      end
      n_tests++;
      if (missed0 !== exp_m) begin
        n_fail++; $display("FAIL holdoff_missed k=%0d got %b exp %b", k, missed0, exp_m);
      end
      if (k == 2 || k == 8 || k == 15) trig0 = 1'b0;
      if (k == 6 || k == 13) trig0 = 1'b1;
    end
    cnt_sel = 2'd2;
    #1;
    n_tests++;
    if (cnt0 !== 16'd2) begin
      n_fail++; $display("FAIL holdoff_cnt got %0d exp 2", cnt0);
    end
  endtask

  task automatic test_select();
    logic [3:0] exp_o;
    do_reset();
    {s1, s0} = 2'b00;
    trig0    = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_o = (k >= 3 && k <= 6) ? 4'b0001 : (k >= 16 && k <= 19) ? 4'b1000 : 4'b0000;
      n_tests++;
      if (o0 !== exp_o) begin
        n_fail++; $display("FAIL select_out k=%0d got %b exp %b", k, o0, exp_o);
      end
      if (k == 2 || k == 15) trig0 = 1'b0;
      if (k == 4) {s1, s0} = 2'b11;
      if (k == 13) trig0 = 1'b1;
    end
    cnt_sel = 2'd0;
    #1;
    n_tests++;
    if (cnt0 !== 16'd1) begin
      n_fail++; $display("FAIL select_cnt_a got %0d exp 1", cnt0);
    end
    cnt_sel = 2'd3;
    #1;
    n_tests++;
    if (cnt0 !== 16'd1) begin
      n_fail++; $display("FAIL select_cnt_d got %0d exp 1", cnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_o;
    do_reset();
    {s1, s0} = 2'b01;
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) begin
        tick();
        exp_o = (k % 4 == 3 && k <= 39) ? 4'b0010 : 4'b0000;
        n_tests++;
        if (o1 !== exp_o) begin
          n_fail++; $display("FAIL fast_out k=%0d got %b exp %b", k, o1, exp_o);
        end
        n_tests++;
        if (missed1 !== 1'b0) begin
          n_fail++; $display("FAIL fast_missed k=%0d got %b exp 0", k, missed1);
        end
      end
      if (k % 4 == 0 && k <= 36) trig1 = 1'b1;
      if (k % 4 == 2) trig1 = 1'b0;
    end
    cnt_sel = 2'd1;
    #1;
    n_tests++;
    if (cnt1 !== 16'd10) begin
      n_fail++; $display("FAIL fast_cnt got %0d exp 10", cnt1);
    end
    // Alternating trig_in gives a rise in the very first IDLE cycle after each pulse.
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        tick();
        exp_o = (k % 2 == 1 && k >= 3 && k <= 11) ? 4'b0010 : 4'b0000;
        n_tests++;
        if (o1 !== exp_o) begin
          n_fail++; $display("FAIL b2b_out k=%0d got %b exp %b", k, o1, exp_o);
        end
      end
      trig1 = (k % 2 == 0 && k <= 8);
    end
    n_tests++;
    if (cnt1 !== 16'd15 || missed1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cnt got %0d/%b exp 15/0", cnt1, missed1);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    {s1, s0} = 2'b00;
    cnt_sel  = 2'd0;
    for (int k = 0; k <= 17 * 16; k++) begin
      if (k > 0) tick();
      if (k % 16 == 0 && k < 17 * 16) trig2 = 1'b1;
      if (k % 16 == 2) trig2 = 1'b0;
    end
    n_tests++;
    if (cnt2 !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt got %0d exp 15", cnt2);
    end
    n_tests++;
    if (missed2 !== 1'b0) begin
      n_fail++; $display("FAIL sat_missed got %b exp 0", missed2);
    end
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) tick();
      if (k == 10) begin
        n_tests++;
        if (missed2 !== 1'b1) begin
          n_fail++; $display("FAIL clr_missed_set got %b exp 1", missed2);
        end
      end
      if (k == 18) begin
        n_tests++;
        if (cnt2 !== 4'd15 || missed2 !== 1'b1) begin
          n_fail++; $display("FAIL clr_before got %0d/%b exp 15/1", cnt2, missed2);
        end
      end
      if (k == 19) begin
        n_tests++;
        if (cnt2 !== 4'd0 || missed2 !== 1'b0) begin
          n_fail++; $display("FAIL clr_after got %0d/%b exp 0/0", cnt2, missed2);
        end
        n_tests++;
        if (o2 !== 4'b0001) begin
          n_fail++; $display("FAIL clr_out got %b exp 0001", o2);
        end
      end
      if (k == 22) begin
        n_tests++;
        if (o2 !== 4'b0001 || busy2 !== 1'b1) begin
          n_fail++; $display("FAIL clr_fsm got %b/%b exp 0001/1", o2, busy2);
        end
      end
      if (k == 0 || k == 6 || k == 16) trig2 = 1'b1;
      if (k == 2 || k == 8 || k == 18) trig2 = 1'b0;
      cnt_clr = (k == 18);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_o;
    logic       exp_busy;
    do_reset();
    {s1, s0} = 2'b01;
    trig0    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_o    = ((k >= 3 && k <= 4) || (k >= 10 && k <= 13)) ? 4'b0010 : 4'b0000;
      exp_busy = (k >= 3 && k <= 4) || (k >= 10 && k <= 21);
      n_tests++;
      if (o0 !== exp_o) begin
        n_fail++; $display("FAIL rstmid_out k=%0d got %b exp %b", k, o0, exp_o);
      end
      n_tests++;
      if (busy0 !== exp_busy) begin
        n_fail++; $display("FAIL rstmid_busy k=%0d got %b exp %b", k, busy0, exp_busy);
      end
      if (k == 4) rst_n = 1'b0;
      if (k == 7) rst_n = 1'b1;
    end
    cnt_sel = 2'd1;
    #1;
    n_tests++;
    if (cnt0 !== 16'd1) begin
      n_fail++; $display("FAIL rstmid_cnt got %0d exp 1", cnt0);
    end
    trig0 = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    trig0   = 1'b0;
    trig1   = 1'b0;
    trig2   = 1'b0;
    s0      = 1'b0;
    s1      = 1'b0;
    cnt_clr = 1'b0;
    cnt_sel = 2'd0;
    test_reset();
    test_basic();
    test_holdoff();
    test_select();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
